vga_timing_generator: RTL and testbench
=======================================

Name: vga_timing_generator

Overview:
- Produces the raster position (cycle, scanline) that drives pixel_generator, plus VGA hsync/vsync/blank.
- Runs on the 100 MHz system clock. Advances one pixel per pixel_clk tick, which is the single-cycle enable from clock_divider.
- Sync and blank outputs are delayed by a programmable number of ticks, so they line up with pixel_data after pixel_generator's memory-fetch latency.

Parameters:
H_VISIBLE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BACK, 48, horizontal back porch (pixels)
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BACK, 33, vertical back porch (lines)
SYNC_DELAY, 2, pixel ticks of delay on hsync/vsync/vga_blank (0..7)
SYNC_ACTIVE, 0, active level of hsync and vsync

Ports:
clk  input  1  system clock (100 MHz)
rst  input  1  asynchronous reset, active-low
pixel_clk  input  1  pixel tick enable, one clk cycle wide
cycle  output  10  horizontal counter, 0..H_TOTAL-1
scanline  output  9  visible line index; 9'h1FF outside the visible lines
v_active  output  1  high while vertical counter < V_VISIBLE
vga_blank  output  1  delayed blanking, high outside the visible area
hsync  output  1  delayed horizontal sync
vsync  output  1  delayed vertical sync
line_start  output  1  one-clk pulse when cycle wraps to 0
frame_start  output  1  one-clk pulse when cycle and the vertical counter both wrap to 0

Behaviour:
- Derived totals: H_TOTAL = sum of the H_* parameters (800); V_TOTAL = sum of the V_* parameters (525). Both totals must be ≤ 1024.
- Internal counters h (10 bit) and v (10 bit). cycle = h.
- Asynchronous reset (rst low): h=0, v=0, cycle=0, scanline=0, v_active=1, vga_blank=1, hsync=vsync=~SYNC_ACTIVE, line_start=frame_start=0. All delay-line stages load blank=1 and inactive sync. Reset takes effect immediately and may occur mid-frame.
- Counters change only on a clk rising edge with pixel_clk=1; with pixel_clk=0 every counter output holds.
- On a tick: if h==H_TOTAL-1 then h←0 and v advances (v==V_TOTAL-1 → 0, else v+1); otherwise h←h+1.
- scanline and v_active are registered from the updated v in the same edge, so they change together with cycle. scanline = v[8:0] when v<V_VISIBLE, else 9'h1FF.
- line_start: high for exactly one clk, the edge that sets h from H_TOTAL-1 to 0; low otherwise, including the following non-tick clks.
- frame_start: same timing, only when v also wraps to 0. It coincides with line_start.
- Raw signals, computed from the current registered counters:
  - blank_raw = (h≥H_VISIBLE) | (v≥V_VISIBLE)
  - hs_raw active when H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC
  - vs_raw active when V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC, for whole lines
- Delay line:
  - SYNC_DELAY register stages, shifted only on ticks.
  - Outputs are the last stage, so the outputs lag the raw signals by SYNC_DELAY ticks.
  - SYNC_DELAY=0: outputs are the raw signals directly, combinational from registered counters.
- Sync outputs drive SYNC_ACTIVE when active and ~SYNC_ACTIVE otherwise.
- pixel_clk asserted on back-to-back clks is legal; each such clk counts as one tick.
- Deasserting reset: the first tick after release moves h 0→1; no pulse is generated on release.

Test Plan:
- Reset: hold rst=0 with pixel_clk toggling → cycle=0, scanline=0, vga_blank=1, hsync=vsync=1, no pulses. Assert rst=0 at h=300, v=100 → all outputs return to reset values without waiting for a clk edge.
- Horizontal sweep, pixel_clk every other clk, default params:
  - cycle steps 0..799 then 0.
  - line_start is one clk wide at the 799→0 wrap.
  - scanline goes 0→1 on that same edge.
- Sync alignment, SYNC_DELAY=2:
  - hsync=0 from cycle 658 through cycle 753 inclusive.
  - vga_blank first rises at cycle 642 and falls at cycle 2 of the next line.
- Vertical/frame, small params (H 8/1/2/1, V 4/1/1/1, SYNC_DELAY=0):
  - scanline sequence 0,1,2,3,1FF,1FF,1FF,0.
  - vsync low only for v=5.
  - frame_start pulses once per 84 ticks, coincident with line_start.
- Stall: hold pixel_clk=0 for 50 clks at cycle=123 → cycle, scanline and all delayed outputs stay frozen. The first tick afterwards gives cycle=124.
- Continuous ticks: pixel_clk=1 on every clk for one line → cycle advances every clk and wraps after 800 clks; the delay pipeline stays consistent.

Source files
------------

// File: rtl/vga_timing_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : vga_timing_generator
// Purpose : Raster counters plus VGA sync/blank, delayed to align with pixels.
// Rev     : 1.0 - initial release
// ============================================================================
module vga_timing_generator #(
   parameter int unsigned H_VISIBLE   = 640,
   parameter int unsigned H_FRONT     = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BACK      = 48,
   parameter int unsigned V_VISIBLE   = 480,
   parameter int unsigned V_FRONT     = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BACK      = 33,
   parameter int unsigned SYNC_DELAY  = 2,
   parameter logic        SYNC_ACTIVE = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       pixel_clk,
   output logic [9:0] cycle,
   output logic [8:0] scanline,
   output logic       v_active,
   output logic       vga_blank,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_start
);

   localparam int unsigned c_h_total = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned c_v_total = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] c_h_last     = 10'(c_h_total - 1);
   localparam logic [9:0] c_v_last     = 10'(c_v_total - 1);
   localparam logic [9:0] c_h_vis      = 10'(H_VISIBLE);
   localparam logic [9:0] c_v_vis      = 10'(V_VISIBLE);
   localparam logic [9:0] c_hs_start   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] c_hs_end     = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] c_vs_start   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] c_vs_end     = 10'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] r_h;
   logic [9:0] r_v;
   logic [8:0] r_scanline;
   logic       r_v_active;
   logic       r_line_start;
   logic       r_frame_start;

   logic       w_h_wrap;
   logic       w_v_wrap;
   logic [9:0] w_h_next;
   logic [9:0] w_v_next;
   logic       w_blank_raw;
   logic       w_hs_raw;
   logic       w_vs_raw;
   logic       w_blank_out;
   logic       w_hs_out;
   logic       w_vs_out;

   always_comb begin
      w_h_wrap = (r_h == c_h_last);
      w_v_wrap = (r_v == c_v_last);
      w_h_next = w_h_wrap ? 10'd0 : r_h + 10'd1;
      w_v_next = r_v;
      if (w_h_wrap) begin
         w_v_next = w_v_wrap ? 10'd0 : r_v + 10'd1;
      end
   end

   // scanline/v_active follow the post-tick v so they move in step with cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_h           <= 10'd0;
         r_v           <= 10'd0;
         r_scanline    <= 9'd0;
         r_v_active    <= 1'b1;
         r_line_start  <= 1'b0;
         r_frame_start <= 1'b0;
      end else begin
         r_line_start  <= pixel_clk & w_h_wrap;
         r_frame_start <= pixel_clk & w_h_wrap & w_v_wrap;
         if (pixel_clk) begin
            r_h        <= w_h_next;
            r_v        <= w_v_next;
            r_v_active <= (w_v_next < c_v_vis);
            r_scanline <= (w_v_next < c_v_vis) ? w_v_next[8:0] : 9'h1FF;
         end
      end
   end

   always_comb begin
      w_blank_raw = (r_h >= c_h_vis) | (r_v >= c_v_vis);
      w_hs_raw    = (r_h >= c_hs_start) & (r_h < c_hs_end);
      w_vs_raw    = (r_v >= c_vs_start) & (r_v < c_vs_end);
   end

   generate
      if (SYNC_DELAY == 0) begin : g_no_delay
         assign w_blank_out = w_blank_raw;
         assign w_hs_out    = w_hs_raw;
         assign w_vs_out    = w_vs_raw;
      end else begin : g_delay
         logic [SYNC_DELAY-1:0] r_blank_dly;
         logic [SYNC_DELAY-1:0] r_hs_dly;
         logic [SYNC_DELAY-1:0] r_vs_dly;
         logic [SYNC_DELAY:0]   w_blank_chain;
         logic [SYNC_DELAY:0]   w_hs_chain;
         logic [SYNC_DELAY:0]   w_vs_chain;

         // Chain bit 0 is the raw input; the top bit is the final stage
         assign w_blank_chain = {r_blank_dly, w_blank_raw};
         assign w_hs_chain    = {r_hs_dly, w_hs_raw};
         assign w_vs_chain    = {r_vs_dly, w_vs_raw};

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               r_blank_dly <= '1;
               r_hs_dly    <= '0;
               r_vs_dly    <= '0;
            end else if (pixel_clk) begin
               r_blank_dly <= w_blank_chain[SYNC_DELAY-1:0];
               r_hs_dly    <= w_hs_chain[SYNC_DELAY-1:0];
               r_vs_dly    <= w_vs_chain[SYNC_DELAY-1:0];
            end
         end

         assign w_blank_out = w_blank_chain[SYNC_DELAY];
         assign w_hs_out    = w_hs_chain[SYNC_DELAY];
         assign w_vs_out    = w_vs_chain[SYNC_DELAY];
      end
   endgenerate

   assign cycle       = r_h;
   assign scanline    = r_scanline;
   assign v_active    = r_v_active;
   assign line_start  = r_line_start;
   assign frame_start = r_frame_start;
   assign vga_blank   = w_blank_out;
   assign hsync       = w_hs_out ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   assign vsync       = w_vs_out ? SYNC_ACTIVE : ~SYNC_ACTIVE;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_vga_timing_generator
// Purpose : Directed bench for vga_timing_generator (default and tiny rasters).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_vga_timing_generator;

   localparam int c_mode_alt  = 0;
   localparam int c_mode_cont = 1;
   localparam int c_mode_hold = 2;

   logic clk       = 1'b0;
   logic rst       = 1'b1;
   logic pixel_clk = 1'b0;
   int   mode      = c_mode_alt;
   bit   chk_en    = 1'b0;
   int   tests     = 0;
   int   fails     = 0;

   // Model state: ticks since reset, and whether the last edge was a tick
   int   n         = 0;
   bit   last_tick = 1'b0;

   logic [9:0] cyc_b, cyc_s;
   logic [8:0] sl_b, sl_s;
   logic       va_b, bl_b, hs_b, vs_b, ls_b, fs_b;
   logic       va_s, bl_s, hs_s, vs_s, ls_s, fs_s;

   always #5 clk = ~clk;

   vga_timing_generator dut (
      .clk(clk), .rst(rst), .pixel_clk(pixel_clk),
      .cycle(cyc_b), .scanline(sl_b), .v_active(va_b), .vga_blank(bl_b),
      .hsync(hs_b), .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b)
   );

   vga_timing_generator #(
      .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .SYNC_DELAY(0), .SYNC_ACTIVE(1'b0)
   ) dut_s (
      .clk(clk), .rst(rst), .pixel_clk(pixel_clk),
      .cycle(cyc_s), .scanline(sl_s), .v_active(va_s), .vga_blank(bl_s),
      .hsync(hs_s), .vsync(vs_s), .line_start(ls_s), .frame_start(fs_s)
   );

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         n         <= 0;
         last_tick <= 1'b0;
      end else begin
         if (pixel_clk) n <= n + 1;
         last_tick <= pixel_clk;
      end
   end

   // Expected outputs from the raster rules: position is the tick count
   // folded into the frame; sync/blank reflect the position d ticks ago.
   function automatic logic [24:0] model(int nt, bit lt, int hv, int hf, int hsw, int hb,
                                         int vv, int vf, int vsw, int vb, int d, bit sa);
      int  ht = hv + hf + hsw + hb;
      int  vt = vv + vf + vsw + vb;
      int  h  = nt % ht;
      int  v  = (nt / ht) % vt;
      int  m, hm, vm;
      logic [8:0] sl;
      logic blank, hsa, vsa, ls, fs;
      sl = (v < vv) ? 9'(v) : 9'h1FF;
      if (nt < d) begin
         blank = 1'b1; hsa = 1'b0; vsa = 1'b0;
      end else begin
         m  = nt - d;
         hm = m % ht;
         vm = (m / ht) % vt;
         blank = (hm >= hv) || (vm >= vv);
         hsa   = (hm >= hv + hf) && (hm < hv + hf + hsw);
         vsa   = (vm >= vv + vf) && (vm < vv + vf + vsw);
      end
      ls = lt && (h == 0) && (nt > 0);
      fs = ls && (v == 0);
      return {10'(h), sl, (v < vv), blank, (hsa ? sa : ~sa), (vsa ? sa : ~sa), ls, fs};
   endfunction

   task automatic cmp_one(input string name, input logic [24:0] act, input logic [24:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s n=%0d: got cyc=%0d sl=%0h va=%b bl=%b hs=%b vs=%b ls=%b fs=%b, expected cyc=%0d sl=%0h va=%b bl=%b hs=%b vs=%b ls=%b fs=%b",
                  name, n, act[24:15], act[14:6], act[5], act[4], act[3], act[2], act[1], act[0],
                  exp[24:15], exp[14:6], exp[5], exp[4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   task automatic cmp_all();
      cmp_one("model_default", {cyc_b, sl_b, va_b, bl_b, hs_b, vs_b, ls_b, fs_b},
              model(n, last_tick, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0));
      cmp_one("model_small", {cyc_s, sl_s, va_s, bl_s, hs_s, vs_s, ls_s, fs_s},
              model(n, last_tick, 8, 1, 2, 1, 4, 1, 1, 1, 0, 1'b0));
   endtask

   always @(negedge clk) begin
      if (chk_en) cmp_all();
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_cycle(input int target);
      int k = 0;
      @(negedge clk);
      while (cyc_b !== 10'(target) && k < 4000) begin
         @(negedge clk);
         k++;
      end
      if (cyc_b !== 10'(target)) begin
         tests++;
         fails++;
         $display("FAIL wait_cycle: timeout, cycle=%0d required=%0d", cyc_b, target);
      end
   endtask

   task automatic wait_line_start();
      int k = 0;
      @(negedge clk);
      while (ls_b !== 1'b1 && k < 4000) begin
         @(negedge clk);
         k++;
      end
      if (ls_b !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL wait_line_start: timeout, line_start=%b required=1", ls_b);
      end
   endtask

   // Pixel tick driver: alternate, continuous or stalled
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (mode)
            c_mode_alt:  pixel_clk = ~pixel_clk;
            c_mode_cont: pixel_clk = 1'b1;
            default:     pixel_clk = 1'b0;
         endcase
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      int fs_cnt;
      int ls_cnt;
      int exp_sl [8];
      exp_sl = '{0, 1, 2, 3, 9'h1FF, 9'h1FF, 9'h1FF, 0};

      // Reset held with ticks toggling
      #1 rst = 1'b0;
      #1 chk_en = 1'b1;
      repeat (10) @(negedge clk);
      chk("rst_cycle", 32'(cyc_b), 32'd0);
      chk("rst_scanline", 32'(sl_b), 32'd0);
      chk("rst_blank", 32'(bl_b), 32'd1);
      chk("rst_hsync", 32'(hs_b), 32'd1);
      chk("rst_vsync", 32'(vs_b), 32'd1);
      chk("rst_line_start", 32'(ls_b), 32'd0);

      // Horizontal sweep, tick every other clk
      @(posedge clk);
      #1 rst = 1'b1;
      wait_cycle(641); chk("blank_641", 32'(bl_b), 32'd0);
      wait_cycle(642); chk("blank_642", 32'(bl_b), 32'd1);
      wait_cycle(657); chk("hsync_657", 32'(hs_b), 32'd1);
      wait_cycle(658); chk("hsync_658", 32'(hs_b), 32'd0);
      wait_cycle(753); chk("hsync_753", 32'(hs_b), 32'd0);
      wait_cycle(754); chk("hsync_754", 32'(hs_b), 32'd1);
      wait_line_start();
      chk("wrap_cycle", 32'(cyc_b), 32'd0);
      chk("wrap_scanline", 32'(sl_b), 32'd1);
      chk("wrap_frame_start", 32'(fs_b), 32'd0);
      @(negedge clk);
      chk("line_start_width", 32'(ls_b), 32'd0);
      wait_cycle(1); chk("blank_next_1", 32'(bl_b), 32'd1);
      wait_cycle(2); chk("blank_next_2", 32'(bl_b), 32'd0);

      // Stall at cycle 123
      wait_cycle(123);
      mode = c_mode_hold;
      repeat (50) @(negedge clk);
      chk("stall_cycle", 32'(cyc_b), 32'd123);
      chk("stall_scanline", 32'(sl_b), 32'd1);
      mode = c_mode_alt;
      repeat (2) @(negedge clk);
      chk("after_stall_cycle", 32'(cyc_b), 32'd124);

      // Continuous ticks for one full line
      mode = c_mode_cont;
      wait_line_start();
      @(negedge clk);
      chk("cont_cycle_1", 32'(cyc_b), 32'd1);
      chk("cont_ls_low", 32'(ls_b), 32'd0);
      repeat (799) @(negedge clk);
      chk("cont_wrap_ls", 32'(ls_b), 32'd1);
      chk("cont_wrap_cycle", 32'(cyc_b), 32'd0);

      // Asynchronous reset mid-frame, away from any clk edge
      wait_cycle(300);
      #2 rst = 1'b0;
      #1;
      chk("async_cycle", 32'(cyc_b), 32'd0);
      chk("async_scanline", 32'(sl_b), 32'd0);
      chk("async_v_active", 32'(va_b), 32'd1);
      chk("async_blank", 32'(bl_b), 32'd1);
      chk("async_hsync", 32'(hs_b), 32'd1);
      chk("async_vsync", 32'(vs_b), 32'd1);
      chk("async_small_cycle", 32'(cyc_s), 32'd0);
      cmp_all();
      repeat (5) @(negedge clk);

      // Tiny raster: 12 ticks per line, 84 ticks per frame
      @(posedge clk);
      #1 rst = 1'b1;
      fs_cnt = 0;
      ls_cnt = 0;
      for (int j = 0; j <= 168; j++) begin
         @(negedge clk);
         if (fs_s === 1'b1) begin
            fs_cnt++;
            chk("small_fs_with_ls", 32'(ls_s), 32'd1);
         end
         if (ls_s === 1'b1) ls_cnt++;
         if (j < 96 && (j % 12) == 5) begin
            chk($sformatf("small_scanline_line%0d", j / 12), 32'(sl_s), 32'(exp_sl[j / 12]));
            chk($sformatf("small_vsync_line%0d", j / 12), 32'(vs_s), ((j / 12) == 5) ? 32'd0 : 32'd1);
         end
      end
      chk("small_frame_count", 32'(fs_cnt), 32'd2);
      chk("small_line_count", 32'(ls_cnt), 32'd14);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
